cp_dmem_dma: RTL and testbench
==============================

// Module: cp_dmem_dma
// PURPOSE
//  Word-streaming DMA front-end driving the bus port (port A) of the control-processor data memory.
//  Accepts a command (start byte address, word count, direction).
//  Write: moves words from an input valid/ready stream into memory.
//  Read: moves words from memory to an output valid/ready stream.
//  Sits between the host/NoC interconnect and the CP data memory; the core keeps port B.
// PARAMETERS
//  DATA_WIDTH   32  word width; equals `DEF_CP_DATA_WIDTH
//  ADDR_WIDTH   16  byte-address width; equals `DEF_CP_D_MEM_ADDR_WIDTH
//  LEN_WIDTH    16  word-count width
//  FIFO_DEPTH    4  read-return FIFO entries; power of two, >=4
// PORTS
//  iClk               in   1           clock, posedge
//  iReset_n           in   1           asynchronous active-low reset
//  iCmd_Valid         in   1           command valid
//  oCmd_Ready         out  1           high only in IDLE
//  iCmd_Write         in   1           1 = stream->mem, 0 = mem->stream
//  iCmd_Address       in   ADDR_WIDTH  start byte address
//  iCmd_Length        in   LEN_WIDTH   number of words
//  iWr_Valid          in   1           write-stream beat valid
//  oWr_Ready          out  1           write-stream ready
//  iWr_Data           in   DATA_WIDTH  write-stream data
//  oRd_Valid          out  1           read-stream beat valid (FIFO not empty)
//  iRd_Ready          in   1           read-stream ready
//  oRd_Data           out  DATA_WIDTH  read-stream data (FIFO head)
//  oBusy              out  1           state != IDLE
//  oDone              out  1           1-cycle completion pulse
//  oError             out  1           1-cycle pulse with oDone on rejected command
//  oMem_Valid         out  1           to memory iBus_Valid (registered)
//  oMem_Address       out  ADDR_WIDTH  to memory iBus_Address, byte address, [1:0]=0
//  oMem_Write_Data    out  DATA_WIDTH  to memory iBus_Write_Data (registered)
//  oMem_Write_Enable  out  1           to memory iBus_Write_Enable (registered)
//  iMem_Read_Data     in   DATA_WIDTH  from memory oBus_Read_Data; valid the cycle after a read
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, counters 0; oCmd_Ready becomes 1 on the first cycle after release.
//  FSM states: IDLE, WRITE, READ, DRAIN, DONE.
//  Command acceptance in IDLE on iCmd_Valid (handshake with oCmd_Ready):
//   - iCmd_Address[1:0]!=0 -> DONE with error flag; no memory access.
//   - iCmd_Length==0 -> DONE, no access.
//   - otherwise -> WRITE or READ; address register = iCmd_Address, remaining = iCmd_Length.
//  WRITE:
//   - oWr_Ready = (remaining!=0).
//   - Beat accepted in cycle N -> oMem_Valid=oMem_Write_Enable=1 in N+1 at the current address.
//   - Address += 4 (wraps mod 2^ADDR_WIDTH); remaining -= 1.
//   - The last beat's write cycle moves to DONE.
//  READ:
//   - Issue a read in cycle K when remaining!=0 and fifo_count+outstanding < FIFO_DEPTH.
//   - oMem_Valid=1, oMem_Write_Enable=0 in K+1.
//   - iMem_Read_Data is sampled in K+2 and pushed into the FIFO; oRd_Valid=1 in K+3.
//   - Sustains 1 word/cycle when iRd_Ready stays high.
//   - remaining==0 after the last issue -> DRAIN.
//  DRAIN: wait for outstanding==0 and FIFO empty (all beats popped), then DONE.
//  DONE: oDone=1 (oError=1 if rejected) for exactly one cycle, then IDLE.
//  Simultaneous push and pop on the FIFO: count unchanged.
//  Pop on empty or push on full is impossible by credit; assert in simulation.
//  oMem_Valid is never asserted in IDLE, DRAIN or DONE.
//  Reset mid-transfer: immediate abort, FIFO flushed, no oDone; in-flight memory data discarded.
//  oMem_Write_Data holds its last value when oMem_Valid=0.
// STRUCTURE
//  The shared CP definitions header supplies DATA_WIDTH/ADDR_WIDTH defaults and the FSM state encodings as `defines.
//  Sub-module: cp_dma_fifo, a synchronous FIFO with async-reset pointers, DATA_WIDTH x FIFO_DEPTH.
//   - Ports: push, pop, din, dout, count, empty.
//  The top level holds the FSM, address/remaining counters, outstanding counter (0..2) and registered memory outputs.
// TESTING
//  Write 4 words A0..A3 @0x0010, stream always valid -> 4 writes at 0x10,0x14,0x18,0x1C on consecutive cycles; oDone 1 cycle after last.
//  Read 4 words @0x0010, iRd_Ready=1 -> oRd_Data A0..A3 back-to-back, first at 3 cycles after issue; oDone after last pop.
//  Read 8 words with iRd_Ready toggling 1/0 -> no loss or duplication; FIFO never exceeds 4; oMem_Valid stalls.
//  Cmd length 0 -> oDone 1 cycle, oError=0, no oMem_Valid; address 0x0012 -> oDone=oError=1, no access.
//  Write 2 words @0xFFFC (ADDR_WIDTH=16) -> writes at 0xFFFC then 0x0000.
//  Assert iReset_n low mid-read of 8 words -> all outputs 0 immediately; next command completes correctly, no stale oRd_Valid.

Source files
------------

// File: rtl/cp_dmem_dma_pkg.sv
// Shared definitions for the CP data-memory DMA front-end: default widths,
// FSM state encodings and a small address helper.
package cp_dmem_dma_pkg;

    localparam int CP_DATA_WIDTH       = 32;
    localparam int CP_D_MEM_ADDR_WIDTH = 16;
    localparam int CP_DMA_LEN_WIDTH    = 16;
    localparam int CP_DMA_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_WRITE = 3'd1,
        DMA_READ  = 3'd2,
        DMA_DRAIN = 3'd3,
        DMA_DONE  = 3'd4
    } dmaState_t;

    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/cp_dma_fifo.sv
// Read-return FIFO for the DMA: async-reset pointers, unreset storage.
// The head word reads as zero while empty so nothing stale leaks out.
module cp_dma_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          iClk,
    input  logic                          iReset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;

    always_ff @(posedge iClk) begin
        if (push) begin
            storage[wrPtr] <= din;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign dout  = empty ? '0 : storage[rdPtr];

    // The DMA issues reads only against free credit, so these can never fire.
    popOnEmpty: assert property (@(posedge iClk) disable iff (!iReset_n) !(pop && empty));
    pushOnFull: assert property (@(posedge iClk) disable iff (!iReset_n) !(push && (count == FULL_COUNT)));

endmodule

// File: rtl/cp_dmem_dma.sv
// Word-streaming DMA driving the bus port of the CP data memory.
// Handshakes: a beat/command transfers on a rising clock edge where valid and ready are both high.
module cp_dmem_dma
    import cp_dmem_dma_pkg::*;
#(
    parameter int DATA_WIDTH = CP_DATA_WIDTH,
    parameter int ADDR_WIDTH = CP_D_MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = CP_DMA_LEN_WIDTH,
    parameter int FIFO_DEPTH = CP_DMA_FIFO_DEPTH
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iCmd_Valid,
    output logic                  oCmd_Ready,
    input  logic                  iCmd_Write,
    input  logic [ADDR_WIDTH-1:0] iCmd_Address,
    input  logic [LEN_WIDTH-1:0]  iCmd_Length,
    input  logic                  iWr_Valid,
    output logic                  oWr_Ready,
    input  logic [DATA_WIDTH-1:0] iWr_Data,
    output logic                  oRd_Valid,
    input  logic                  iRd_Ready,
    output logic [DATA_WIDTH-1:0] oRd_Data,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError,
    output logic                  oMem_Valid,
    output logic [ADDR_WIDTH-1:0] oMem_Address,
    output logic [DATA_WIDTH-1:0] oMem_Write_Data,
    output logic                  oMem_Write_Enable,
    input  logic [DATA_WIDTH-1:0] iMem_Read_Data,
    output logic [2:0]            oDbg_State
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    dmaState_t             state;
    dmaState_t             stateNext;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [1:0]            outstanding;
    logic                  errFlag;
    logic                  cmdEnable;
    logic                  rdSample;

    logic                  memValid;
    logic                  memWriteEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWriteData;

    logic                  cmdFire;
    logic                  cmdAligned;
    logic                  wrFire;
    logic                  rdIssue;
    logic                  rdPop;
    logic [CNT_W-1:0]      fifoCount;
    logic                  fifoEmpty;
    logic [CNT_W:0]        creditUsed;

    assign cmdAligned = isWordAligned(iCmd_Address[1:0]);
    assign cmdFire    = oCmd_Ready && iCmd_Valid;
    assign wrFire     = oWr_Ready && iWr_Valid;
    assign rdPop      = oRd_Valid && iRd_Ready;

    // Words already in the FIFO plus reads still in the memory pipeline.
    assign creditUsed = {1'b0, fifoCount} + {{(CNT_W - 1){1'b0}}, outstanding};
    assign rdIssue    = (state == DMA_READ) && (remaining != '0) && (creditUsed < CREDIT_LIMIT);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= DMA_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            DMA_IDLE: begin
                if (cmdFire) begin
                    if (!cmdAligned || (iCmd_Length == '0)) begin
                        stateNext = DMA_DONE;
                    end else if (iCmd_Write) begin
                        stateNext = DMA_WRITE;
                    end else begin
                        stateNext = DMA_READ;
                    end
                end
            end
            // remaining hits zero during the cycle that carries the final access
            DMA_WRITE: if (remaining == '0) stateNext = DMA_DONE;
            DMA_READ:  if (remaining == '0) stateNext = DMA_DRAIN;
            DMA_DRAIN: if ((outstanding == 2'd0) && fifoEmpty) stateNext = DMA_DONE;
            DMA_DONE:  stateNext = DMA_IDLE;
            default:   stateNext = DMA_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            addrReg      <= '0;
            remaining    <= '0;
            errFlag      <= 1'b0;
            cmdEnable    <= 1'b0;
            outstanding  <= 2'd0;
            rdSample     <= 1'b0;
            memValid     <= 1'b0;
            memWriteEn   <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
        end else begin
            cmdEnable <= 1'b1;
            if (cmdFire) begin
                addrReg   <= iCmd_Address;
                remaining <= cmdAligned ? iCmd_Length : '0;
                errFlag   <= !cmdAligned;
            end else if (wrFire || rdIssue) begin
                addrReg   <= addrReg + ADDR_WIDTH'(4);
                remaining <= remaining - LEN_WIDTH'(1);
            end

            memValid   <= wrFire || rdIssue;
            memWriteEn <= wrFire;
            if (wrFire || rdIssue) memAddr <= addrReg;
            if (wrFire) memWriteData <= iWr_Data;

            // Memory returns read data one cycle after the registered request.
            rdSample <= memValid && !memWriteEn;

            case ({rdIssue, rdSample})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    cp_dma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .push     (rdSample),
        .pop      (rdPop),
        .din      (iMem_Read_Data),
        .dout     (oRd_Data),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

    assign oCmd_Ready        = (state == DMA_IDLE) && cmdEnable;
    assign oWr_Ready         = (state == DMA_WRITE) && (remaining != '0);
    assign oRd_Valid         = !fifoEmpty;
    assign oBusy             = (state != DMA_IDLE);
    assign oDone             = (state == DMA_DONE);
    assign oError            = (state == DMA_DONE) && errFlag;
    assign oMem_Valid        = memValid;
    assign oMem_Address      = memAddr;
    assign oMem_Write_Data   = memWriteData;
    assign oMem_Write_Enable = memWriteEn;
    assign oDbg_State        = state;

endmodule

// File: tb/tb_cp_dmem_dma.sv
// Directed bench for cp_dmem_dma with a registered-read memory model and a
// read-stream scoreboard.
module tb_cp_dmem_dma;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;

    logic          iClk = 1'b0;
    logic          iReset_n = 1'b0;
    logic          iCmd_Valid = 1'b0;
    logic          oCmd_Ready;
    logic          iCmd_Write = 1'b0;
    logic [AW-1:0] iCmd_Address = '0;
    logic [LW-1:0] iCmd_Length = '0;
    logic          iWr_Valid = 1'b0;
    logic          oWr_Ready;
    logic [DW-1:0] iWr_Data = '0;
    logic          oRd_Valid;
    logic          iRd_Ready = 1'b0;
    logic [DW-1:0] oRd_Data;
    logic          oBusy;
    logic          oDone;
    logic          oError;
    logic          oMem_Valid;
    logic [AW-1:0] oMem_Address;
    logic [DW-1:0] oMem_Write_Data;
    logic          oMem_Write_Enable;
    logic [DW-1:0] iMem_Read_Data;
    logic [2:0]    oDbg_State;

    cp_dmem_dma dut (
        .iClk              (iClk),
        .iReset_n          (iReset_n),
        .iCmd_Valid        (iCmd_Valid),
        .oCmd_Ready        (oCmd_Ready),
        .iCmd_Write        (iCmd_Write),
        .iCmd_Address      (iCmd_Address),
        .iCmd_Length       (iCmd_Length),
        .iWr_Valid         (iWr_Valid),
        .oWr_Ready         (oWr_Ready),
        .iWr_Data          (iWr_Data),
        .oRd_Valid         (oRd_Valid),
        .iRd_Ready         (iRd_Ready),
        .oRd_Data          (oRd_Data),
        .oBusy             (oBusy),
        .oDone             (oDone),
        .oError            (oError),
        .oMem_Valid        (oMem_Valid),
        .oMem_Address      (oMem_Address),
        .oMem_Write_Data   (oMem_Write_Data),
        .oMem_Write_Enable (oMem_Write_Enable),
        .iMem_Read_Data    (iMem_Read_Data),
        .oDbg_State        (oDbg_State)
    );

    // clock / reset
    always #5 iClk = ~iClk;
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // memory model: registered read, data valid the cycle after the request
    logic [DW-1:0] memArray [0:16383];
    logic [DW-1:0] memRd;
    always @(posedge iClk) begin
        if (oMem_Valid) begin
            if (oMem_Write_Enable) memArray[oMem_Address[AW-1:2]] <= oMem_Write_Data;
            else                   memRd <= memArray[oMem_Address[AW-1:2]];
        end
    end
    assign iMem_Read_Data = memRd;

    // checking
    int nChecks = 0;
    int nErrors = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard and access monitor
    logic [DW-1:0] exp_q[$];
    logic [31:0]   accAddr[$];
    logic [31:0]   accData[$];
    logic [31:0]   accWe[$];
    int            accCyc[$];
    int            popCyc[$];
    int            firstRdValidCyc = -1;
    int            doneCnt = 0;
    int            issued = 0;
    int            popped = 0;
    int            maxInFlight = 0;

    always @(negedge iClk) begin
        if (iReset_n) begin
            if (oMem_Valid) begin
                accAddr.push_back(32'(oMem_Address));
                accData.push_back(oMem_Write_Data);
                accWe.push_back(32'(oMem_Write_Enable));
                accCyc.push_back(cyc);
                if (!oMem_Write_Enable) issued++;
            end
            if (oRd_Valid && (firstRdValidCyc < 0)) firstRdValidCyc = cyc;
            if (oRd_Valid && iRd_Ready) begin
                popped++;
                popCyc.push_back(cyc);
                check("rd_data", oRd_Data, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx);
            end
            if (issued - popped > maxInFlight) maxInFlight = issued - popped;
            if (oDone) doneCnt++;
        end
    end

    task automatic clearLogs();
        exp_q.delete();
        accAddr.delete();
        accData.delete();
        accWe.delete();
        accCyc.delete();
        popCyc.delete();
        firstRdValidCyc = -1;
        doneCnt = 0;
        issued = 0;
        popped = 0;
        maxInFlight = 0;
    endtask

    // driver tasks
    task automatic sendCmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           output int fireCyc);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        @(posedge iClk);
        #1;
        iCmd_Valid = 1'b1;
        iCmd_Write = wr;
        iCmd_Address = addr;
        iCmd_Length = len;
        do begin
            @(negedge iClk);
            rdy = oCmd_Ready;
            @(posedge iClk);
            #1;
            n++;
        end while (!rdy && (n < 50));
        fireCyc = cyc;
        check("cmd_accept", 32'(rdy), 32'd1);
        iCmd_Valid = 1'b0;
    endtask

    task automatic writeStream(input int n, input logic [DW-1:0] base, input bit toggle);
        int   idx;
        int   guard;
        logic acc;
        idx = 0;
        guard = 0;
        iWr_Data = base;
        iWr_Valid = 1'b1;
        while ((idx < n) && (guard < 200)) begin
            @(negedge iClk);
            acc = oWr_Ready && iWr_Valid;
            @(posedge iClk);
            #1;
            guard++;
            if (acc) idx++;
            iWr_Data = base + DW'(idx);
            iWr_Valid = toggle ? ~iWr_Valid : 1'b1;
        end
        iWr_Valid = 1'b0;
        check("wr_beats", 32'(idx), 32'(n));
    endtask

    task automatic waitDone(input int maxCyc, input bit toggleRd, output int doneCyc, output logic err);
        int n;
        n = 0;
        doneCyc = -1;
        err = 1'b0;
        while ((n < maxCyc) && (doneCyc < 0)) begin
            @(negedge iClk);
            if (oDone) begin
                doneCyc = cyc;
                err = oError;
            end
            if (toggleRd) begin
                @(posedge iClk);
                #1;
                iRd_Ready = ~iRd_Ready;
            end
            n++;
        end
        check("done_seen", 32'(doneCyc >= 0), 32'd1);
        @(negedge iClk);
        check("done_one_cycle", 32'(oDone), 32'd0);
        check("idle_after_done", 32'(oCmd_Ready), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rd_data"}, oRd_Data, 32'd0);
        check({tag, "_mem_wdata"}, oMem_Write_Data, 32'd0);
        check({tag, "_mem_addr"}, 32'(oMem_Address), 32'd0);
        check({tag, "_ctrl"}, 32'({oCmd_Ready, oWr_Ready, oRd_Valid, oBusy, oDone, oError,
                                   oMem_Valid, oMem_Write_Enable}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fireCyc;
        int   doneCyc;
        logic err;

        // reset state
        #2;
        checkAllZero("reset");
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        iReset_n = 1'b1;
        check("ready_before_first_edge", 32'(oCmd_Ready), 32'd0);
        @(negedge iClk);
        check("ready_after_release", 32'(oCmd_Ready), 32'd1);
        check("dbg_state_idle", 32'(oDbg_State), 32'd0);

        // write 4 words @0x0010, stream always valid
        clearLogs();
        sendCmd(1'b1, 16'h0010, 16'd4, fireCyc);
        writeStream(4, 32'hA0A0_0000, 1'b0);
        waitDone(20, 1'b0, doneCyc, err);
        check("wr4_count", 32'(accAddr.size()), 32'd4);
        for (int i = 0; i < 4 && i < accAddr.size(); i++) begin
            check("wr4_addr", accAddr[i], 32'h10 + 32'(4 * i));
            check("wr4_data", accData[i], 32'hA0A0_0000 + 32'(i));
            check("wr4_we", accWe[i], 32'd1);
            check("wr4_consecutive", 32'(accCyc[i] - accCyc[0]), 32'(i));
        end
        if (accCyc.size() == 4) check("wr4_done_latency", 32'(doneCyc - accCyc[3]), 32'd1);
        check("wr4_err", 32'(err), 32'd0);

        // read 4 words back @0x0010 with the stream always ready
        clearLogs();
        iRd_Ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A0_0000 + 32'(i));
        sendCmd(1'b0, 16'h0010, 16'd4, fireCyc);
        waitDone(40, 1'b0, doneCyc, err);
        check("rd4_pops", 32'(popped), 32'd4);
        check("rd4_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rd4_accesses", 32'(accAddr.size()), 32'd4);
        for (int i = 0; i < 4 && i < accAddr.size(); i++) begin
            check("rd4_addr", accAddr[i], 32'h10 + 32'(4 * i));
            check("rd4_we", accWe[i], 32'd0);
        end
        if (accCyc.size() > 0) check("rd4_first_latency", 32'(firstRdValidCyc - accCyc[0]), 32'd2);
        if (popCyc.size() == 4) begin
            check("rd4_back_to_back", 32'(popCyc[3] - popCyc[0]), 32'd3);
            check("rd4_done_after_pop", 32'(doneCyc - popCyc[3]), 32'd2);
        end

        // write 8 words @0x0100 with a gappy stream
        clearLogs();
        sendCmd(1'b1, 16'h0100, 16'd8, fireCyc);
        writeStream(8, 32'hB000_0000, 1'b1);
        waitDone(20, 1'b0, doneCyc, err);
        check("wr8_count", 32'(accAddr.size()), 32'd8);
        for (int i = 0; i < 8 && i < accAddr.size(); i++) begin
            check("wr8_addr", accAddr[i], 32'h100 + 32'(4 * i));
            check("wr8_data", accData[i], 32'hB000_0000 + 32'(i));
        end

        // read 8 words with iRd_Ready toggling
        clearLogs();
        iRd_Ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
        sendCmd(1'b0, 16'h0100, 16'd8, fireCyc);
        waitDone(100, 1'b1, doneCyc, err);
        check("rd8_pops", 32'(popped), 32'd8);
        check("rd8_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rd8_issued", 32'(issued), 32'd8);
        check("rd8_inflight_le_depth", 32'(maxInFlight <= 4), 32'd1);
        if (accCyc.size() == 8) check("rd8_issue_stalled", 32'((accCyc[7] - accCyc[0]) > 7), 32'd1);
        iRd_Ready = 1'b1;

        // zero length: done right away, no access, no error
        clearLogs();
        sendCmd(1'b0, 16'h0020, 16'd0, fireCyc);
        waitDone(10, 1'b0, doneCyc, err);
        check("len0_done_cycle", 32'(doneCyc), 32'(fireCyc));
        check("len0_err", 32'(err), 32'd0);
        check("len0_no_access", 32'(accAddr.size()), 32'd0);

        // misaligned address: done with error, no access
        clearLogs();
        sendCmd(1'b1, 16'h0012, 16'd4, fireCyc);
        waitDone(10, 1'b0, doneCyc, err);
        check("misalign_done_cycle", 32'(doneCyc), 32'(fireCyc));
        check("misalign_err", 32'(err), 32'd1);
        check("misalign_no_access", 32'(accAddr.size()), 32'd0);

        // address wrap at the top of the space
        clearLogs();
        sendCmd(1'b1, 16'hFFFC, 16'd2, fireCyc);
        writeStream(2, 32'hC0C0_0000, 1'b0);
        waitDone(20, 1'b0, doneCyc, err);
        check("wrap_count", 32'(accAddr.size()), 32'd2);
        if (accAddr.size() == 2) begin
            check("wrap_addr0", accAddr[0], 32'hFFFC);
            check("wrap_addr1", accAddr[1], 32'h0000);
            check("wrap_data1", accData[1], 32'hC0C0_0001);
        end

        // reset in the middle of an 8-word read
        clearLogs();
        iRd_Ready = 1'b0;
        sendCmd(1'b0, 16'h0100, 16'd8, fireCyc);
        repeat (6) @(posedge iClk);
        #1;
        check("pre_reset_rd_valid", 32'(oRd_Valid), 32'd1);
        iReset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        check("post_reset_ready", 32'(oCmd_Ready), 32'd1);
        check("post_reset_rd_valid", 32'(oRd_Valid), 32'd0);
        check("post_reset_no_done", 32'(doneCnt), 32'd0);

        clearLogs();
        iRd_Ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0A0_0000 + 32'(i));
        sendCmd(1'b0, 16'h0010, 16'd4, fireCyc);
        waitDone(40, 1'b0, doneCyc, err);
        check("after_reset_pops", 32'(popped), 32'd4);
        check("after_reset_sb_empty", 32'(exp_q.size()), 32'd0);
        if (accCyc.size() > 0) check("after_reset_no_stale", 32'(firstRdValidCyc - accCyc[0]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
